// File: rtl/data_read_pkg.sv
// Shared types and defaults for the LVDS capture path.
// LVDS_CAP_TRIG_EN adds the ARMED state and the trigger comparator.
package data_read_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } cap_state_t;

    localparam int LVDS_DEPTH       = 512;
    localparam int LVDS_ADDR_W      = 9;
    localparam int LVDS_DATA_W      = 4;
    localparam int LVDS_SYNC_STAGES = 2;

endpackage

// File: rtl/lvds_toggle_sync.sv
// Toggle synchronizer into LVDS_CLK: sync chain plus history flop,
// producing a one-cycle pulse per level change of the toggle.
module lvds_toggle_sync
    import data_read_pkg::*;
#(
    parameter int SYNC_STAGES = LVDS_SYNC_STAGES
) (
    input  logic LVDS_CLK,
    input  logic lvds_resetn,
    input  logic tgl,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge LVDS_CLK or negedge lvds_resetn) begin
        if (!lvds_resetn) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/lvds_capture_ctrl.sv
// Write-side controller for the LVDS sample buffer.
// Define LVDS_CAP_TRIG_EN to wait for a trigger pattern before capturing.
module lvds_capture_ctrl
    import data_read_pkg::*;
#(
    parameter int DEPTH       = LVDS_DEPTH,
    parameter int ADDR_W      = LVDS_ADDR_W,
    parameter int DATA_W      = LVDS_DATA_W,
    parameter int SYNC_STAGES = LVDS_SYNC_STAGES
) (
    input  logic              LVDS_CLK,
    input  logic              lvds_resetn,
    input  logic              start_tgl,
    input  logic              abort_tgl,
    input  logic [DATA_W-1:0] lvds_in,
    input  logic [DATA_W-1:0] trig_pattern,
    input  logic [DATA_W-1:0] trig_mask,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              done_tgl,
    output logic              busy,
    output logic              aborted,
    output logic              start_lost
);

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              wr_en_d;
    logic              done_d;
    logic              aborted_d;
    logic              lost_d;
    logic              start_p;
    logic              abort_p;
    logic              trig_hit;
    logic              last_wr;

    lvds_toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_start_sync (
        .LVDS_CLK   (LVDS_CLK),
        .lvds_resetn(lvds_resetn),
        .tgl        (start_tgl),
        .pulse      (start_p)
    );

    lvds_toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_abort_sync (
        .LVDS_CLK   (LVDS_CLK),
        .lvds_resetn(lvds_resetn),
        .tgl        (abort_tgl),
        .pulse      (abort_p)
    );

`ifdef LVDS_CAP_TRIG_EN
    localparam cap_state_t START_TO = ARMED;
    assign trig_hit = ((lvds_in ^ trig_pattern) & trig_mask) == '0;
`else
    localparam cap_state_t START_TO = CAPTURE;
    logic unused_trig;
    assign unused_trig = ^{trig_pattern, trig_mask};
    assign trig_hit    = 1'b1;
`endif

    // Capture ends on the terminal address, never on the counter wrap
    assign last_wr = wr_addr == ADDR_W'(DEPTH - 1);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        wr_en_d   = 1'b0;
        done_d    = done_tgl;
        aborted_d = aborted;
        lost_d    = start_lost;
        if (start_p && state_q != IDLE) begin
            lost_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start_p && !abort_p) begin
                    aborted_d = 1'b0;
                    lost_d    = 1'b0;
                    state_d   = START_TO;
                    if (START_TO == CAPTURE) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = lvds_in;
                    end
                end
            end
            ARMED: begin
                if (abort_p) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (trig_hit) begin
                    state_d   = CAPTURE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = lvds_in;
                end
            end
            CAPTURE: begin
                // Completion takes priority over a coincident abort
                if (last_wr) begin
                    state_d = IDLE;
                    done_d  = ~done_tgl;
                end else if (abort_p) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr + 1'b1;
                    wr_data_d = lvds_in;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge LVDS_CLK or negedge lvds_resetn) begin
        if (!lvds_resetn) begin
            state_q    <= IDLE;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            done_tgl   <= 1'b0;
            busy       <= 1'b0;
            aborted    <= 1'b0;
            start_lost <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            wr_en      <= wr_en_d;
            done_tgl   <= done_d;
            busy       <= state_d != IDLE;
            aborted    <= aborted_d;
            start_lost <= lost_d;
        end
    end

endmodule

// File: tb/tb_lvds_capture_ctrl.sv
// Randomized scoreboard bench for lvds_capture_ctrl (either trigger build).
module tb_lvds_capture_ctrl;

    localparam int S  = 2;
    localparam int D  = 512;
    localparam int NS = 16384;

    typedef struct packed {
        logic [8:0] a;
        logic [3:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       lvds_resetn = 1'b0;
    logic       start_tgl = 1'b0;
    logic       abort_tgl = 1'b0;
    logic [3:0] lvds_in = 4'h0;
    logic [3:0] pat = 4'h0;
    logic [3:0] msk = 4'h0;
    logic [8:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_en;
    logic       done_tgl;
    logic       busy;
    logic       aborted;
    logic       start_lost;

    int  cmp_n = 0;
    int  err_n = 0;
    int  edge_cnt = 0;
    logic [3:0] samp [NS];
    wr_t exp_q [$];
    logic exp_done = 1'b0;
    logic exp_ab = 1'b0;
    logic exp_lost = 1'b0;
    logic prev_done = 1'b0;

    lvds_capture_ctrl dut (
        .LVDS_CLK    (clk),
        .lvds_resetn (lvds_resetn),
        .start_tgl   (start_tgl),
        .abort_tgl   (abort_tgl),
        .lvds_in     (lvds_in),
        .trig_pattern(pat),
        .trig_mask   (msk),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .done_tgl    (done_tgl),
        .busy        (busy),
        .aborted     (aborted),
        .start_lost  (start_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Value seen by the DUT at edge n is samp[n]
    always @(negedge clk) begin
        if (edge_cnt + 1 < NS) lvds_in = samp[edge_cnt+1];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!lvds_resetn) begin
            prev_done = 1'b0;
        end else begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {19'd0, wr_addr, wr_data}, 32'hFFFFFFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write", {18'd0, busy, wr_addr, wr_data},
                        {18'd0, 1'b1, e.a, e.d});
                end
            end
            if (done_tgl !== prev_done) begin
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("wren_at_done", {31'd0, wr_en}, 32'd0);
                prev_done = done_tgl;
            end
        end
    end

    // Edge at which the first write lands, given the start was seen at edge k
    function automatic int cap_edge(int k);
`ifdef LVDS_CAP_TRIG_EN
        int e = k + S + 1;
        while (e < NS - 1 && ((samp[e] ^ pat) & msk) != 4'h0) e++;
        return e;
`else
        return k + S;
`endif
    endfunction

    task automatic chk_flags(string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_tgl}, {31'd0, exp_done});
        chk({tag, "_aborted"}, {31'd0, aborted}, {31'd0, exp_ab});
        chk({tag, "_start_lost"}, {31'd0, start_lost}, {31'd0, exp_lost});
        chk({tag, "_queue"}, exp_q.size(), 32'd0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_addr"}, {23'd0, wr_addr}, 32'd0);
        chk({tag, "_data"}, {28'd0, wr_data}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_tgl}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
        chk({tag, "_start_lost"}, {31'd0, start_lost}, 32'd0);
    endtask

    // ab_off/st2_off: write index at which an abort / second start acts (-1 none)
    task automatic run_cap(string tag, int ab_off, int st2_off,
                           bit do_rst, bit demo);
        int j, c, nw, ab_e, s2_e;
        bit completes;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        j = edge_cnt;
        if (demo) begin
            for (int i = j + 2; i <= j + S + 20; i++) samp[i] = 4'h5;
            samp[j+S+21] = 4'hA;
        end
        start_tgl = ~start_tgl;
        c = cap_edge(j + 1);
        nw = D;
        completes = 1'b1;
        ab_e = -1;
        s2_e = -1;
        if (ab_off >= 0) begin
            ab_e = c + ab_off - 1 - S;
            if (ab_off < D) begin
                nw = ab_off;
                completes = 1'b0;
            end
        end
        if (st2_off >= 0) s2_e = c + st2_off - 1 - S;
        if (do_rst) nw = 301;
        for (int i = 0; i < nw; i++) begin
            wr_t w;
            w.a = 9'(i);
            w.d = samp[c+i];
            exp_q.push_back(w);
        end
        exp_ab = 1'b0;
        exp_lost = (st2_off >= 0);
        if (!do_rst) begin
            if (completes) exp_done = ~exp_done;
            else exp_ab = 1'b1;
        end
        while (1) begin
            @(negedge clk);
            if (edge_cnt == ab_e) abort_tgl = ~abort_tgl;
            if (edge_cnt == s2_e) start_tgl = ~start_tgl;
            if (do_rst && edge_cnt == c + 300) begin
                #2;
                lvds_resetn = 1'b0;
                start_tgl = 1'b0;
                abort_tgl = 1'b0;
                #1;
                chk_zero({tag, "_rst"});
                chk({tag, "_queue"}, exp_q.size(), 32'd0);
                exp_q.delete();
                exp_done = 1'b0;
                exp_ab = 1'b0;
                exp_lost = 1'b0;
                repeat (3) @(negedge clk);
                lvds_resetn = 1'b1;
                break;
            end
            if (edge_cnt >= c + nw + 3) break;
        end
        if (!do_rst) chk_flags(tag);
    endtask

    task automatic both_idle();
        @(negedge clk);
        start_tgl = ~start_tgl;
        abort_tgl = ~abort_tgl;
        repeat (S + 6) @(negedge clk);
        chk("both_wr_en", {31'd0, wr_en}, 32'd0);
        chk_flags("both");
    endtask

    initial begin
        for (int i = 0; i < NS; i++) samp[i] = 4'($urandom_range(0, 15));
        pat = 4'hA;
        msk = 4'hF;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        lvds_resetn = 1'b1;
        repeat (2) @(negedge clk);
        run_cap("plain1", -1, -1, 1'b0, 1'b0);
        run_cap("trigA", -1, -1, 1'b0, 1'b1);
        pat = 4'($urandom_range(0, 15));
        run_cap("plain2", -1, -1, 1'b0, 1'b0);
        run_cap("abort100", 100, -1, 1'b0, 1'b0);
        both_idle();
        run_cap("clear_ab", -1, -1, 1'b0, 1'b0);
        run_cap("lost", -1, 50, 1'b0, 1'b0);
        msk = 4'h0;
        run_cap("clear_lost", -1, -1, 1'b0, 1'b0);
        msk = 4'hF;
        run_cap("abort511", D, -1, 1'b0, 1'b0);
        run_cap("rst300", -1, -1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        run_cap("after_rst", -1, -1, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
